// File: rtl/axi_read_responder.sv
// AXI read-channel responder: accepts one AR burst at a time, reads each beat from a
// single-port memory with one cycle of latency and returns it on the R channel.
module axi_read_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  ARVALID,
    output logic                  ARREADY,
    input  logic [ADDR_WIDTH-1:0] ARADDR,
    input  logic [7:0]            ARLEN,
    input  logic [1:0]            ARBURST,
    input  logic [ID_WIDTH-1:0]   ARID,
    output logic                  RVALID,
    input  logic                  RREADY,
    output logic [DATA_WIDTH-1:0] RDATA,
    output logic [1:0]            RRESP,
    output logic                  RLAST,
    output logic [ID_WIDTH-1:0]   RID,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_SEND  = 2'd3;

    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(BEAT_BYTES - ADDR_WIDTH'(1));

    logic [1:0]            state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [7:0]            cnt_q,    cnt_d;
    logic [1:0]            burst_q,  burst_d;
    logic                  err_q,    err_d;
    logic [ID_WIDTH-1:0]   rid_q,    rid_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q,  rdata_d;
    logic [1:0]            rresp_q,  rresp_d;
    logic                  rlast_q,  rlast_d;

    // ARREADY is forced low while reset is held, even though the state is already IDLE.
    assign ARREADY   = (state_q == S_IDLE) && !ARESET;
    assign mem_rd_en = (state_q == S_FETCH) && !err_q;
    assign mem_addr  = addr_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign RLAST     = rlast_q;
    assign RID       = rid_q;

    always_comb begin
        // NOTE: every _d starts as its _q so no path through the case can infer a latch.
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        burst_d  = burst_q;
        err_d    = err_q;
        rid_d    = rid_q;
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rlast_d  = rlast_q;

        case (state_q)
            S_IDLE: begin
                if (ARVALID && ARREADY) begin
                    addr_d  = ARADDR & ALIGN_MASK;
                    cnt_d   = ARLEN;
                    burst_d = ARBURST;
                    rid_d   = ARID;
                    err_d   = ARBURST[1];
                    state_d = S_FETCH;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                rdata_d  = err_q ? '0 : mem_rdata;
                rresp_d  = err_q ? RESP_SLVERR : RESP_OKAY;
                rlast_d  = (cnt_q == 8'd0);
                rvalid_d = 1'b1;
                state_d  = S_SEND;
            end
            default: begin
                if (rvalid_q && RREADY) begin
                    rvalid_d = 1'b0;
                    if (cnt_q == 8'd0) begin
                        rlast_d = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        cnt_d   = cnt_q - 8'd1;
                        // FIXED bursts re-read the same word; wrap past the top of the space is intended.
                        if (burst_q == BURST_INCR) addr_d = addr_q + BEAT_BYTES;
                        state_d = S_FETCH;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments; reset is synchronous, checked first.
        if (ARESET) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            cnt_q    <= '0;
            burst_q  <= '0;
            err_q    <= 1'b0;
            rid_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= '0;
            rlast_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            burst_q  <= burst_d;
            err_q    <= err_d;
            rid_q    <= rid_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
            rlast_q  <= rlast_d;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: directed and random bursts checked against a
// burst-level model of the expected beats and memory reads.
module tb_axi_read_responder;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        ARVALID;
    logic        ARREADY;
    logic [15:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [1:0]  ARBURST;
    logic [3:0]  ARID;
    logic        RVALID;
    logic        RREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic [3:0]  RID;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:16383];
    logic [15:0] rd_log [$];

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    axi_read_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .ID_WIDTH(4)) dut (
        .ACLK      (ACLK),
        .ARESET    (ARESET),
        .ARVALID   (ARVALID),
        .ARREADY   (ARREADY),
        .ARADDR    (ARADDR),
        .ARLEN     (ARLEN),
        .ARBURST   (ARBURST),
        .ARID      (ARID),
        .RVALID    (RVALID),
        .RREADY    (RREADY),
        .RDATA     (RDATA),
        .RRESP     (RRESP),
        .RLAST     (RLAST),
        .RID       (RID),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata)
    );

    always #5 ACLK = ~ACLK;

    // Memory with one cycle of read latency; outside a read the bus carries junk.
    always @(posedge ACLK) begin
        if (mem_rd_en) mem_rdata <= mem[mem_addr[15:2]];
        else           mem_rdata <= $urandom;
    end

    always @(negedge ACLK) begin
        if (mem_rd_en) rd_log.push_back(mem_addr);
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic wait_rvalid(input int bound);
        int n = 0;
        while (!RVALID && n < bound) begin
            @(negedge ACLK);
            n++;
        end
        if (!RVALID) check("rvalid_timeout", 64'd0, 64'd1);
    endtask

    task automatic run_burst(input logic [15:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input logic [3:0] id, input int stall_beat, input int stall_cycles,
                             input bit rand_ready);
        beat_t       exp_q [$];
        logic [15:0] exp_rd [$];
        logic [15:0] base;
        logic [15:0] a;
        bit          err;
        beat_t       b;
        int          beat;
        int          lat;
        int          last_hs_lat;
        int          stall_left;
        int          guard;
        bit          seen;
        bit          pending;

        // Expected beats derived straight from the burst rules.
        err  = (burst == 2'b10) || (burst == 2'b11);
        base = addr & 16'hFFFC;
        for (int i = 0; i <= int'(len); i++) begin
            a      = (burst == 2'b01) ? 16'(base + 16'(4 * i)) : base;
            b.data = err ? 32'd0 : mem[a[15:2]];
            b.resp = err ? 2'b10 : 2'b00;
            b.last = (i == int'(len));
            exp_q.push_back(b);
            if (!err) exp_rd.push_back(a);
        end

        @(negedge ACLK);
        rd_log.delete();
        check("arready_idle", ARREADY, 1'b1);
        ARVALID = 1'b1;
        ARADDR  = addr;
        ARLEN   = len;
        ARBURST = burst;
        ARID    = id;
        RREADY  = rand_ready ? 1'($urandom) : 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        ARADDR  = 16'($urandom);
        ARLEN   = 8'($urandom);
        ARID    = 4'($urandom);
        check("rd_en_latency", mem_rd_en, !err);

        beat        = 0;
        lat         = 1;
        last_hs_lat = 0;
        stall_left  = stall_cycles;
        guard       = 0;
        seen        = 1'b0;
        pending     = 1'b0;
        while (beat <= int'(len) && guard < 400) begin
            check("arready_busy", ARREADY, 1'b0);
            if (pending) check("rvalid_hold", RVALID, 1'b1);
            if (RVALID) begin
                if (!seen) begin
                    if (beat == 0) check("first_beat_latency", 64'(lat), 64'd3);
                    else if (!rand_ready && stall_cycles == 0)
                        check("beat_period", 64'(lat - last_hs_lat), 64'd3);
                    seen = 1'b1;
                end
                check("rdata", RDATA, exp_q[beat].data);
                check("rresp", RRESP, exp_q[beat].resp);
                check("rlast", RLAST, exp_q[beat].last);
                check("rid",   RID,   id);
            end
            if (RVALID && beat == stall_beat && stall_left > 0) begin
                RREADY = 1'b0;
                stall_left--;
            end else begin
                RREADY = rand_ready ? 1'($urandom) : 1'b1;
            end
            pending = RVALID && !RREADY;
            if (RVALID && RREADY) begin
                beat++;
                last_hs_lat = lat;
                seen = 1'b0;
            end
            @(negedge ACLK);
            lat++;
            guard++;
        end
        if (beat <= int'(len)) check("burst_timeout", 64'(beat), 64'(len) + 64'd1);

        check("arready_after_last", ARREADY, 1'b1);
        check("rvalid_after_last", RVALID, 1'b0);
        check("rd_count", 64'(rd_log.size()), 64'(exp_rd.size()));
        for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
            check("mem_addr", rd_log[i], exp_rd[i]);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = $urandom;
        mem[16'h0010 >> 2] = 32'hDEADBEEF;

        ARESET  = 1'b1;
        ARVALID = 1'b0;
        ARADDR  = '0;
        ARLEN   = '0;
        ARBURST = '0;
        ARID    = '0;
        RREADY  = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_arready",   ARREADY,   1'b0);
        check("rst_rvalid",    RVALID,    1'b0);
        check("rst_rdata",     RDATA,     32'd0);
        check("rst_rresp",     RRESP,     2'b00);
        check("rst_rlast",     RLAST,     1'b0);
        check("rst_rid",       RID,       4'd0);
        check("rst_mem_rd_en", mem_rd_en, 1'b0);
        check("rst_mem_addr",  mem_addr,  16'd0);
        ARESET = 1'b0;
        #1;
        check("arready_release", ARREADY, 1'b1);

        run_burst(16'h0010, 8'd0, 2'b01, 4'd3, -1, 0, 1'b0);
        run_burst(16'h0102, 8'd3, 2'b01, 4'd1, -1, 0, 1'b0);
        run_burst(16'h0020, 8'd2, 2'b00, 4'd2, -1, 0, 1'b0);
        run_burst(16'h0300, 8'd3, 2'b01, 4'd4,  1, 5, 1'b0);
        run_burst(16'h0040, 8'd1, 2'b10, 4'd5, -1, 0, 1'b0);
        run_burst(16'h0044, 8'd2, 2'b11, 4'd6, -1, 0, 1'b1);
        run_burst(16'hFFF9, 8'd3, 2'b01, 4'd9, -1, 0, 1'b0);

        // Reset while beat 2 of 4 sits in SEND.
        @(negedge ACLK);
        ARVALID = 1'b1;
        ARADDR  = 16'h0200;
        ARLEN   = 8'd3;
        ARBURST = 2'b01;
        ARID    = 4'd7;
        RREADY  = 1'b1;
        @(negedge ACLK);
        ARVALID = 1'b0;
        wait_rvalid(10);
        @(negedge ACLK);
        RREADY = 1'b0;
        wait_rvalid(10);
        check("mid_beat2_rdata", RDATA, mem[16'h0204 >> 2]);
        ARESET = 1'b1;
        @(posedge ACLK);
        #1;
        check("mid_rst_rvalid",    RVALID,    1'b0);
        check("mid_rst_mem_rd_en", mem_rd_en, 1'b0);
        check("mid_rst_arready",   ARREADY,   1'b0);
        check("mid_rst_rlast",     RLAST,     1'b0);
        @(negedge ACLK);
        ARESET = 1'b0;
        RREADY = 1'b1;
        #1;
        check("mid_rst_arready_release", ARREADY, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            check("no_residual_beat", RVALID, 1'b0);
        end
        run_burst(16'h0010, 8'd0, 2'b01, 4'd3, -1, 0, 1'b0);

        for (int t = 0; t < 25; t++) begin
            run_burst(16'($urandom), 8'($urandom_range(0, 7)), 2'($urandom), 4'($urandom),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 4)), 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
